// File: rtl/fifo_wr_packer.sv
// Serialises 16-bit ALU results and 8-bit register-file bytes into
// FIFO byte pushes, stalling on full and counting rejected requests.
module fifo_wr_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  input  logic                    rf_valid,
  input  logic                    full,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    w_inc,
  output logic                    busy,
  output logic                    drop,
  output logic [7:0]              drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALU_LO = 2'd1,
    ALU_HI = 2'd2,
    RF     = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [2*DATA_WIDTH-1:0] hold;
  logic [2*DATA_WIDTH-1:0] hold_n;
  logic                    reject;

  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      state    <= IDLE;
      hold     <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      busy  <= (state_n != IDLE);
      drop  <= reject;
      if (reject && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Both valids in one cycle still count as a single rejection.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    reject  = 1'b0;
    unique case (state)
      IDLE: begin
        if (alu_valid) begin
          state_n = ALU_LO;
          hold_n  = alu_out;
          reject  = rf_valid;
        end else if (rf_valid) begin
          state_n = RF;
          hold_n[DATA_WIDTH-1:0] = rf_data;
        end
      end
      ALU_LO: begin
        reject = alu_valid | rf_valid;
        if (w_inc) state_n = ALU_HI;
      end
      ALU_HI: begin
        reject = alu_valid | rf_valid;
        if (w_inc) state_n = IDLE;
      end
      RF: begin
        reject = alu_valid | rf_valid;
        if (w_inc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    w_inc   = w_rst & (state != IDLE) & ~full;
    wr_data = '0;
    unique case (state)
      ALU_LO:  wr_data = hold[DATA_WIDTH-1:0];
      RF:      wr_data = hold[DATA_WIDTH-1:0];
      ALU_HI:  wr_data = hold[2*DATA_WIDTH-1:DATA_WIDTH];
      default: wr_data = '0;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: reset, ALU/RF pushes,
// back-pressure, rejections, saturation and reset mid-transfer.
module tb_fifo_wr_packer;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic [7:0]  rf_data;
  logic        rf_valid;
  logic        full;
  logic [7:0]  wr_data;
  logic        w_inc;
  logic        busy;
  logic        drop;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;
  int p0;
  logic [7:0] log_q[$];

  fifo_wr_packer #(.DATA_WIDTH(8)) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .alu_out   (alu_out),
    .alu_valid (alu_valid),
    .rf_data   (rf_data),
    .rf_valid  (rf_valid),
    .full      (full),
    .wr_data   (wr_data),
    .w_inc     (w_inc),
    .busy      (busy),
    .drop      (drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk)
    if (w_inc) log_q.push_back(wr_data);

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    w_rst = 1'b0;
    alu_out = 16'hFFFF;
    alu_valid = 1'b1;
    rf_data = 8'h00;
    rf_valid = 1'b0;
    full = 1'b0;

    // reset with a pending ALU request
    step();
    step();
    chk("rst_winc", 16'(w_inc), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_wrdata", 16'(wr_data), 16'd0);
    chk("rst_dropcnt", 16'(drop_cnt), 16'd0);
    chk("rst_drop", 16'(drop), 16'd0);
    w_rst = 1'b1;
    alu_valid = 1'b0;
    step();
    step();
    chk("rst_nopush", 16'(log_q.size()), 16'd0);
    chk("rst_idle", 16'(busy), 16'd0);

    // basic ALU
    p0 = log_q.size();
    alu_out = 16'hA55A;
    alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    chk("alu_busy0", 16'(busy), 16'd1);
    chk("alu_winc0", 16'(w_inc), 16'd1);
    chk("alu_lo", 16'(wr_data), 16'h5A);
    step();
    chk("alu_busy1", 16'(busy), 16'd1);
    chk("alu_hi", 16'(wr_data), 16'hA5);
    chk("alu_drop", 16'(drop), 16'd0);
    step();
    chk("alu_done", 16'(busy), 16'd0);
    chk("alu_winc_off", 16'(w_inc), 16'd0);
    chk("alu_npush", 16'(log_q.size() - p0), 16'd2);
    chk("alu_push0", 16'(log_q[p0]), 16'h5A);
    chk("alu_push1", 16'(log_q[p0+1]), 16'hA5);

    // back-pressure
    p0 = log_q.size();
    alu_out = 16'h1234;
    alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    full = 1'b1;
    #1;
    chk("bp_stall_winc", 16'(w_inc), 16'd0);
    chk("bp_stall_data", 16'(wr_data), 16'h34);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_winc", 16'(w_inc), 16'd0);
      chk("bp_hold_data", 16'(wr_data), 16'h34);
      chk("bp_hold_busy", 16'(busy), 16'd1);
    end
    full = 1'b0;
    #1;
    chk("bp_resume_winc", 16'(w_inc), 16'd1);
    step();
    chk("bp_hi", 16'(wr_data), 16'h12);
    step();
    chk("bp_done", 16'(busy), 16'd0);
    step();
    chk("bp_npush", 16'(log_q.size() - p0), 16'd2);
    chk("bp_push0", 16'(log_q[p0]), 16'h34);
    chk("bp_push1", 16'(log_q[p0+1]), 16'h12);

    // simultaneous, then in-flight RF during ALU_HI
    p0 = log_q.size();
    alu_out = 16'hBEEF;
    rf_data = 8'h77;
    alu_valid = 1'b1;
    rf_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    rf_valid = 1'b0;
    chk("sim_drop", 16'(drop), 16'd1);
    chk("sim_cnt", 16'(drop_cnt), 16'd1);
    chk("sim_lo", 16'(wr_data), 16'hEF);
    step();
    chk("sim_drop_off", 16'(drop), 16'd0);
    rf_valid = 1'b1;
    step();
    rf_valid = 1'b0;
    chk("inf_drop", 16'(drop), 16'd1);
    chk("inf_cnt", 16'(drop_cnt), 16'd2);
    step();
    chk("inf_drop_off", 16'(drop), 16'd0);
    chk("sim_npush", 16'(log_q.size() - p0), 16'd2);
    chk("sim_push0", 16'(log_q[p0]), 16'hEF);
    chk("sim_push1", 16'(log_q[p0+1]), 16'hBE);

    // saturation: stall an ALU transfer and fire 300 rejected requests
    full = 1'b1;
    alu_out = 16'h0000;
    alu_valid = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 99) chk("sat_mid", 16'(drop_cnt), 16'd102);
    end
    chk("sat_cnt", 16'(drop_cnt), 16'd255);
    chk("sat_drop", 16'(drop), 16'd1);
    alu_valid = 1'b0;
    step();
    step();
    chk("sat_hold", 16'(drop_cnt), 16'd255);
    chk("sat_drop_off", 16'(drop), 16'd0);
    full = 1'b0;
    step();
    step();
    chk("sat_idle", 16'(busy), 16'd0);

    // reset mid-transfer in ALU_HI
    p0 = log_q.size();
    alu_out = 16'h5678;
    alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    step();
    chk("mid_hi", 16'(wr_data), 16'h56);
    w_rst = 1'b0;
    #1;
    chk("mid_winc_forced", 16'(w_inc), 16'd0);
    step();
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_data", 16'(wr_data), 16'd0);
    chk("mid_cnt", 16'(drop_cnt), 16'd0);
    w_rst = 1'b1;
    rf_data = 8'hC3;
    rf_valid = 1'b1;
    step();
    rf_valid = 1'b0;
    chk("rf_winc", 16'(w_inc), 16'd1);
    chk("rf_data", 16'(wr_data), 16'hC3);
    chk("rf_busy", 16'(busy), 16'd1);
    step();
    chk("rf_done", 16'(busy), 16'd0);
    step();
    chk("mid_npush", 16'(log_q.size() - p0), 16'd2);
    chk("mid_push0", 16'(log_q[p0]), 16'h78);
    chk("mid_push1", 16'(log_q[p0+1]), 16'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
